// File: rtl/exec_sequencer.sv
// exec_sequencer: fetch/execute/memory sequencer for a small accumulator CPU (optional macro SEQ_TIMEOUT_EN).
// Latency: 2 cycles per ALU/jump/branch instruction, 3 + memory wait cycles per load/store.
// Backpressure: holds mem_req in MEM until mem_ack; with SEQ_TIMEOUT_EN gives up after TIMEOUT cycles (Err, HALT).
module exec_sequencer #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter logic [3:0]      HALT_OP  = 4'hF,
  parameter int              TIMEOUT  = 15
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [8:0]      Instruction,
  input  logic            jump_en,
  input  logic            br_taken,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic [PC_W-1:0] Target,
  input  logic            mem_ack,
  output logic [PC_W-1:0] PC,
  output logic            ir_load,
  output logic            wb_en,
  output logic            mem_req,
  output logic            mem_we,
  output logic            Busy,
  output logic            Done,
  output logic            Err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic            we_q, we_d;
  logic            is_halt;
  logic            is_mem;
  logic            redirect;
  logic            unused_instr;

  // Natural wrap of the adder gives all-ones -> 0.
  assign pc_inc       = pc_q + PC_W'(1);
  assign is_halt      = (Instruction[8:5] == HALT_OP);
  assign is_mem       = mem_rd | mem_wr;
  assign redirect     = jump_en | br_taken;
  // Operand field is decoded elsewhere; only the opcode matters here.
  assign unused_instr = ^Instruction[4:0];

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timeout_hit;

  // Counter holds the number of MEM cycles already spent without an ack.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  // State and datapath registers; reset wins in every state, including mid-handshake.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      we_q    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      we_q    <= we_d;
`ifdef SEQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state, PC update and the single-cycle write-back strobe.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    we_d    = we_q;
    wb_en   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_FETCH;
          pc_d    = START_PC;
`ifdef SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_mem) begin
          // A simultaneous read and write request is executed as a store.
          state_d = S_MEM;
          we_d    = mem_wr;
`ifdef SEQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = S_FETCH;
          wb_en   = ~redirect;
          pc_d    = redirect ? Target : pc_inc;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d = S_FETCH;
          wb_en   = ~we_q;
          pc_d    = pc_inc;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_HALT: begin
        if (!Start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign PC      = pc_q;
  assign ir_load = (state_q == S_FETCH);
  assign mem_req = (state_q == S_MEM);
  assign mem_we  = mem_req & we_q;
  assign Busy    = (state_q == S_FETCH) | (state_q == S_EXEC) | (state_q == S_MEM);
  assign Done    = (state_q == S_HALT);
`ifdef SEQ_TIMEOUT_EN
  assign Err     = err_q;
`else
  assign Err     = 1'b0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: table vectors, reset/timeout corner sequences and a randomized program run.
// Latency: lockstep with the DUT, one vector per clock, outputs sampled on the falling edge.
// Backpressure: the bench plays the memory and decides when mem_ack arrives.
module tb_exec_sequencer;
  localparam int PC_W = 10;

  // Flag field order: {ir_load, wb_en, mem_req, mem_we, Busy, Done, Err}
  localparam logic [6:0] IDL = 7'b0000000;
  localparam logic [6:0] FET = 7'b1000100;
  localparam logic [6:0] EX  = 7'b0000100;
  localparam logic [6:0] EXW = 7'b0100100;
  localparam logic [6:0] MR  = 7'b0010100;
  localparam logic [6:0] MRA = 7'b0110100;
  localparam logic [6:0] MW  = 7'b0011100;
  localparam logic [6:0] HLT = 7'b0000010;

  logic            Clk = 1'b0;
  logic            Reset, Start, jump_en, br_taken, mem_rd, mem_wr, mem_ack;
  logic [8:0]      Instruction;
  logic [PC_W-1:0] Target;
  logic [PC_W-1:0] PC;
  logic            ir_load, wb_en, mem_req, mem_we, Busy, Done, Err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  exec_sequencer #(.PC_W(PC_W), .START_PC(10'h000), .HALT_OP(4'hF), .TIMEOUT(15)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .jump_en(jump_en), .br_taken(br_taken), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .Target(Target), .mem_ack(mem_ack), .PC(PC), .ir_load(ir_load), .wb_en(wb_en),
    .mem_req(mem_req), .mem_we(mem_we), .Busy(Busy), .Done(Done), .Err(Err)
  );

  typedef struct {
    logic       start;
    logic [3:0] op;
    logic       jmp, br, rd, wr, ack;
    logic [9:0] tgt;
    logic [6:0] fl;
    logic [9:0] pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, input logic [3:0] op, input logic jmp, input logic br,
                     input logic rd, input logic wr, input logic ack, input logic [9:0] tgt,
                     input logic [6:0] fl, input logic [9:0] pc);
    vec_t v;
    v.start = st; v.op = op; v.jmp = jmp; v.br = br; v.rd = rd; v.wr = wr; v.ack = ack;
    v.tgt = tgt; v.fl = fl; v.pc = pc;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] obs();
    return {15'd0, ir_load, wb_en, mem_req, mem_we, Busy, Done, Err, PC};
  endfunction

  function automatic logic [31:0] ex(input logic [6:0] fl, input logic [9:0] pc);
    return {15'd0, fl, pc};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [3:0] op, input logic jmp, input logic br,
                       input logic rd, input logic wr, input logic ack, input logic [9:0] tgt);
    Start       = st;
    Instruction = {op, 5'($urandom)};
    jump_en     = jmp;
    br_taken    = br;
    mem_rd      = rd;
    mem_wr      = wr;
    mem_ack     = ack;
    Target      = tgt;
  endtask

  task automatic sample();
    @(negedge Clk);
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    logic       jmp, br, rd, wr, ack, mem, wb, req, we;
    logic [9:0] tgt, pc_m;
    int         d, len, cnt;

    // ---------------- reset state ----------------
    Reset = 1'b0;
    drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h155);
    next_cycle();
    next_cycle();
    sample();
    chk("reset", obs(), ex(IDL, 10'h000));
    next_cycle();
    Reset = 1'b1;

    // ---------------- table-driven vectors ----------------
    //   st  op    jmp br  rd  wr  ack tgt      flags pc
    add(1, 4'h0, 0, 0, 0, 0, 0, 10'h000, IDL, 10'h000); // Start in IDLE
    add(0, 4'h0, 0, 0, 0, 0, 1, 10'h000, FET, 10'h000); // stray ack in FETCH
    add(0, 4'h1, 0, 0, 0, 0, 0, 10'h000, EXW, 10'h000); // ALU op 1
    add(0, 4'h0, 0, 0, 0, 0, 0, 10'h000, FET, 10'h001);
    add(0, 4'h2, 0, 0, 0, 0, 0, 10'h000, EXW, 10'h001); // ALU op 2
    add(0, 4'h0, 0, 0, 0, 0, 0, 10'h000, FET, 10'h002);
    add(0, 4'h3, 0, 0, 0, 0, 0, 10'h000, EXW, 10'h002); // ALU op 3
    add(0, 4'h0, 0, 0, 0, 0, 0, 10'h000, FET, 10'h003);
    add(0, 4'hF, 0, 0, 0, 0, 0, 10'h000, EX,  10'h003); // halt opcode
    add(0, 4'h0, 0, 0, 0, 0, 0, 10'h000, HLT, 10'h003); // HALT, Start low
    add(1, 4'h0, 0, 0, 0, 0, 0, 10'h000, IDL, 10'h003); // IDLE holds PC, restart
    add(0, 4'h0, 0, 0, 0, 0, 0, 10'h000, FET, 10'h000);
    add(0, 4'h4, 1, 0, 0, 0, 0, 10'h005, EX,  10'h000); // jump to 5
    add(1, 4'h0, 0, 0, 0, 0, 0, 10'h000, FET, 10'h005); // Start while busy ignored
    add(0, 4'h5, 1, 0, 0, 0, 0, 10'h3FF, EX,  10'h005); // jump to 3FF, no wb
    add(0, 4'h0, 0, 0, 0, 0, 0, 10'h000, FET, 10'h3FF);
    add(0, 4'h6, 0, 0, 0, 0, 0, 10'h123, EXW, 10'h3FF); // ALU op, PC wraps
    add(0, 4'h0, 0, 0, 0, 0, 0, 10'h000, FET, 10'h000);
    add(0, 4'h7, 0, 1, 0, 0, 0, 10'h007, EX,  10'h000); // branch taken to 7
    add(0, 4'h0, 0, 0, 0, 0, 0, 10'h000, FET, 10'h007);
    add(0, 4'h8, 0, 0, 1, 0, 1, 10'h000, EX,  10'h007); // LW, ack in EXEC ignored
    add(0, 4'h8, 0, 0, 1, 0, 0, 10'h000, MR,  10'h007);
    add(0, 4'h8, 0, 0, 1, 0, 0, 10'h000, MR,  10'h007);
    add(0, 4'h8, 0, 0, 1, 0, 0, 10'h000, MR,  10'h007);
    add(0, 4'h8, 0, 0, 1, 0, 1, 10'h000, MRA, 10'h007); // 4th MEM cycle acks
    add(0, 4'h0, 0, 0, 0, 0, 0, 10'h000, FET, 10'h008);
    add(0, 4'h9, 1, 0, 1, 1, 0, 10'h055, EX,  10'h008); // rd+wr+jump -> store
    add(0, 4'h9, 1, 0, 1, 1, 1, 10'h055, MW,  10'h008);
    add(0, 4'h0, 0, 0, 0, 0, 0, 10'h000, FET, 10'h009);
    add(0, 4'hF, 1, 0, 1, 0, 0, 10'h0AA, EX,  10'h009); // halt beats jump/mem
    add(1, 4'h0, 0, 0, 0, 0, 0, 10'h000, HLT, 10'h009); // Start high holds HALT
    add(0, 4'h0, 0, 0, 0, 0, 0, 10'h000, HLT, 10'h009);
    add(0, 4'h0, 0, 0, 0, 0, 0, 10'h000, IDL, 10'h009);

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].op, tbl[i].jmp, tbl[i].br, tbl[i].rd, tbl[i].wr,
            tbl[i].ack, tbl[i].tgt);
      sample();
      chk($sformatf("vec%0d", i), obs(), ex(tbl[i].fl, tbl[i].pc));
      next_cycle();
    end

    // ---------------- reset in the middle of a memory wait ----------------
    drive(1, 4'h0, 0, 0, 0, 0, 0, 10'h000); next_cycle();          // IDLE -> FETCH
    drive(0, 4'h0, 0, 0, 0, 0, 0, 10'h000); next_cycle();          // FETCH
    drive(0, 4'h1, 1, 0, 0, 0, 0, 10'h020); next_cycle();          // jump to 20
    drive(0, 4'h0, 0, 0, 0, 0, 0, 10'h000); next_cycle();          // FETCH
    drive(0, 4'h8, 0, 0, 1, 0, 0, 10'h000); next_cycle();          // LW
    drive(0, 4'h8, 0, 0, 1, 0, 0, 10'h000);
    sample(); chk("mem1", obs(), ex(MR, 10'h020)); next_cycle();
    Reset = 1'b0;
    sample(); chk("mem2", obs(), ex(MR, 10'h020)); next_cycle();
    Reset = 1'b1;
    drive(0, 4'h0, 0, 0, 1, 0, 1, 10'h000);                        // late ack
    sample(); chk("rst_mem", obs(), ex(IDL, 10'h000)); next_cycle();
    sample(); chk("rst_ack_ignored", obs(), ex(IDL, 10'h000)); next_cycle();

    // ---------------- memory never acknowledges ----------------
    drive(1, 4'h0, 0, 0, 0, 0, 0, 10'h000); next_cycle();
    drive(0, 4'h0, 0, 0, 0, 0, 0, 10'h000); next_cycle();
    drive(0, 4'h8, 0, 0, 1, 0, 0, 10'h000); next_cycle();
    cnt = 0;
`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      sample();
      if (!mem_req) break;
      cnt++;
      next_cycle();
    end
    chk("timeout_len", 32'(cnt), 32'd15);
    chk("timeout_halt", obs(), ex(HLT | 7'b0000001, 10'h000));
    next_cycle();
    drive(0, 4'h0, 0, 0, 0, 0, 0, 10'h000);
    sample(); chk("err_sticky", obs(), ex(IDL | 7'b0000001, 10'h000)); next_cycle();
    drive(1, 4'h0, 0, 0, 0, 0, 0, 10'h000); next_cycle();
    drive(0, 4'h0, 0, 0, 0, 0, 0, 10'h000);
    sample(); chk("err_clear", obs(), ex(FET, 10'h000)); next_cycle();
`else
    for (int i = 0; i < 100; i++) begin
      sample();
      if (mem_req) cnt++;
      next_cycle();
    end
    chk("wait_forever", 32'(cnt), 32'd100);
    sample(); chk("still_waiting", obs(), ex(MR, 10'h000));
    next_cycle();
`endif

    // ---------------- randomized program against the model ----------------
    Reset = 1'b0;
    next_cycle();
    Reset = 1'b1;
    drive(1, 4'h0, 0, 0, 0, 0, 0, 10'h000);
    sample(); chk("rnd_start", obs(), ex(IDL, 10'h000)); next_cycle();
    pc_m = 10'h000;
    for (int k = 0; k < 60; k++) begin
      op  = 4'($urandom_range(0, 14));
      jmp = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 4) == 0);
      rd  = ($urandom_range(0, 3) == 0);
      wr  = ($urandom_range(0, 4) == 0);
      tgt = 10'($urandom);
      d   = int'($urandom_range(0, 5));
      mem = rd | wr;
      len = mem ? 3 + d : 2;
      for (int p = 0; p < len; p++) begin
        ack = (p < 2) ? 1'($urandom_range(0, 1)) : 1'(p - 2 == d);
        drive(1'($urandom_range(0, 1)), op, jmp, br, rd, wr, ack, tgt);
        wb  = (p == 1 && !mem && !(jmp || br)) || (mem && p == len - 1 && !wr);
        req = mem && (p >= 2);
        we  = req && wr;
        sample();
        chk($sformatf("rnd%0d.%0d", k, p), obs(), ex({1'(p == 0), wb, req, we, 3'b100}, pc_m));
        next_cycle();
      end
      pc_m = (!mem && (jmp || br)) ? tgt : pc_m + 10'd1;
    end
    drive(1, 4'h0, 0, 0, 0, 0, 0, 10'h000);
    sample(); chk("rnd_fetch_halt", obs(), ex(FET, pc_m)); next_cycle();
    drive(0, 4'hF, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 0, 0, 10'h3C3);
    sample(); chk("rnd_exec_halt", obs(), ex(EX, pc_m)); next_cycle();
    drive(0, 4'h0, 0, 0, 0, 0, 1, 10'h000);
    sample(); chk("rnd_halt", obs(), ex(HLT, pc_m)); next_cycle();
    sample(); chk("rnd_idle", obs(), ex(IDL, pc_m)); next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
